// File: rtl/trap_redirect_ctrl.sv
// Owns every PC redirect: branch/jal/jalr, ecall, mret and timer interrupt.
// Traps run the mepc/mcause/mstatus CSR write sequence before redirecting the IFU.
module trap_redirect_ctrl #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] CAUSE_ECALL = 64'd11,
  parameter logic [XLEN-1:0] CAUSE_MTI   = 64'h8000_0000_0000_0007
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            ecall,
  input  logic            mret,
  input  logic            timer_irq,
  input  logic            irq_en,
  input  logic [XLEN-1:0] mtvec_rd,
  input  logic [XLEN-1:0] mepc_rd,
  input  logic [XLEN-1:0] mstatus_rd,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy,
  output logic            flush
);

  typedef enum logic [2:0] {
    StIdle, StWrMepc, StWrMcause, StWrMstatus, StRedirect
  } state_e;

  typedef enum logic [1:0] {KindBranch, KindMret, KindEcall, KindIrq} kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [XLEN-1:0] pc_q, target_q, mstatus_q;
  logic            irq_take, accept, is_trap;
  logic [XLEN-1:0] trap_mstatus, mret_mstatus;

  assign irq_take = timer_irq & irq_en;
  assign accept   = (state_q == StIdle) & valid_in & (irq_take | ecall | mret | branch_taken);
  assign is_trap  = (kind_q == KindEcall) || (kind_q == KindIrq);

  always_comb begin
    kind_d = KindBranch;
    if (irq_take)   kind_d = KindIrq;
    else if (ecall) kind_d = KindEcall;
    else if (mret)  kind_d = KindMret;
  end

  always_comb begin
    trap_mstatus         = mstatus_q;
    trap_mstatus[7]      = mstatus_q[3];
    trap_mstatus[3]      = 1'b0;
    trap_mstatus[12:11]  = 2'b11;
    mret_mstatus         = mstatus_q;
    mret_mstatus[3]      = mstatus_q[7];
    mret_mstatus[7]      = 1'b1;
    mret_mstatus[12:11]  = 2'b11;
  end

  always_comb begin
    state_d        = state_q;
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (kind_d)
            KindIrq, KindEcall: state_d = StWrMepc;
            KindMret:           state_d = StWrMstatus;
            default:            state_d = StRedirect;
          endcase
        end
      end
      StWrMepc: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = pc_q;
        state_d   = StWrMcause;
      end
      StWrMcause: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = (kind_q == KindIrq) ? CAUSE_MTI : CAUSE_ECALL;
        state_d   = StWrMstatus;
      end
      StWrMstatus: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = is_trap ? trap_mstatus : mret_mstatus;
        state_d   = StRedirect;
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        // Trap vector is read live; only direct mode is supported.
        redirect_pc    = is_trap ? {mtvec_rd[XLEN-1:2], 2'b00} : target_q;
        if (redirect_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign flush = accept & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      kind_q    <= KindBranch;
      pc_q      <= '0;
      target_q  <= '0;
      mstatus_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q    <= kind_d;
        pc_q      <= pc_in;
        target_q  <= (kind_d == KindMret) ? mepc_rd : branch_target;
        mstatus_q <= mstatus_rd;
      end
    end
  end

endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// Directed vector bench for trap_redirect_ctrl: table of single events plus
// backpressure and mid-sequence reset sequences.
module tb_trap_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, branch_taken, ecall, mret, timer_irq, irq_en, redirect_ready;
  logic [63:0] pc_in, branch_target, mtvec_rd, mepc_rd, mstatus_rd;
  logic        csr_we, redirect_valid, busy, flush;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata, redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trap_redirect_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .pc_in          (pc_in),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .ecall          (ecall),
    .mret           (mret),
    .timer_irq      (timer_irq),
    .irq_en         (irq_en),
    .mtvec_rd       (mtvec_rd),
    .mepc_rd        (mepc_rd),
    .mstatus_rd     (mstatus_rd),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .busy           (busy),
    .flush          (flush)
  );

  // kind: 0 none, 1 branch, 2 mret, 3 trap
  typedef struct {
    logic        br, ec, mr, irq, ien;
    logic [63:0] pc, tgt, mepc, mtvec, ms;
    int          kind;
    logic [63:0] cause, exp_ms, exp_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; branch_taken = 1'b0; ecall = 1'b0; mret = 1'b0;
    timer_irq = 1'b0; irq_en = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    valid_in = 1'b1; branch_taken = v.br; ecall = v.ec; mret = v.mr;
    timer_irq = v.irq; irq_en = v.ien; pc_in = v.pc; branch_target = v.tgt;
    mepc_rd = v.mepc; mtvec_rd = v.mtvec; mstatus_rd = v.ms;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    redirect_ready = 1'b1;
    drive_vec(v);
    #1;
    check("flush_at_accept", 64'(flush), 64'(v.kind != 0));
    check("busy_at_accept", 64'(busy), 64'd0);
    @(negedge clk);
    idle_inputs();
    if (v.kind == 0) begin
      check("noevent_busy", 64'(busy), 64'd0);
      check("noevent_we", 64'(csr_we), 64'd0);
    end else begin
      if (v.kind == 3) begin
        check("mepc_we", 64'(csr_we), 64'd1);
        check("mepc_addr", 64'(csr_waddr), 64'h341);
        check("mepc_data", csr_wdata, v.pc);
        @(negedge clk);
        check("mcause_addr", 64'(csr_waddr), 64'h342);
        check("mcause_data", csr_wdata, v.cause);
        @(negedge clk);
      end
      if (v.kind >= 2) begin
        check("mstatus_we", 64'(csr_we), 64'd1);
        check("mstatus_addr", 64'(csr_waddr), 64'h300);
        check("mstatus_data", csr_wdata, v.exp_ms);
        @(negedge clk);
      end
      check("redir_valid", 64'(redirect_valid), 64'd1);
      check("redir_pc", redirect_pc, v.exp_pc);
      check("redir_we", 64'(csr_we), 64'd0);
      check("redir_busy", 64'(busy), 64'd1);
      check("redir_flush", 64'(flush), 64'd0);
      @(negedge clk);
      check("post_busy", 64'(busy), 64'd0);
      check("post_valid", 64'(redirect_valid), 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000, 64'h8000_0100, 64'h0,
                64'h8000_1003, 64'h0, 1, 64'h0, 64'h0, 64'h8000_0100};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0040, 64'h0, 64'h0,
                64'h8000_1003, 64'h8, 3, 64'd11, 64'h1880, 64'h8000_1000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0060, 64'h0, 64'h8000_0044,
                64'h8000_1003, 64'h80, 2, 64'h0, 64'h1888, 64'h8000_0044};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0050, 64'h8000_0900, 64'h0,
                64'h8000_2000, 64'h8, 3, 64'h8000_0000_0000_0007, 64'h1880, 64'h8000_2000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8000_0054, 64'h8000_0900, 64'h0,
                64'h8000_2001, 64'h8, 3, 64'd11, 64'h1880, 64'h8000_2000};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0058, 64'h0, 64'h0,
                64'h8000_2000, 64'h0, 0, 64'h0, 64'h0, 64'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0070, 64'h0, 64'h0,
                64'h8000_3002, 64'hA000_0000_0000_000A, 3, 64'h8000_0000_0000_0007,
                64'hA000_0000_0000_1882, 64'h8000_3000};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0080, 64'h8000_0900, 64'h8000_0200,
                64'h8000_1000, 64'h0, 2, 64'h0, 64'h1880, 64'h8000_0200};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0090, 64'h0, 64'h8000_0444,
                64'h8000_1000, 64'h1888, 3, 64'h8000_0000_0000_0007, 64'h1880, 64'h8000_1000};

    rst_n = 1'b0;
    redirect_ready = 1'b1;
    pc_in = '0; branch_target = '0; mtvec_rd = '0; mepc_rd = '0; mstatus_rd = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_we", 64'(csr_we), 64'd0);
    check("rst_valid", 64'(redirect_valid), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure: branch held in REDIRECT while valid_in/ecall pulses are ignored.
    @(negedge clk);
    redirect_ready = 1'b0;
    drive_vec(vecs[0]);
    branch_target = 64'h8000_0300;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      valid_in = c[0]; ecall = 1'b1; timer_irq = 1'b1; irq_en = 1'b1;
      #1;
      check("bp_valid", 64'(redirect_valid), 64'd1);
      check("bp_pc", redirect_pc, 64'h8000_0300);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_flush", 64'(flush), 64'd0);
      @(negedge clk);
    end
    valid_in = 1'b1;
    redirect_ready = 1'b1;
    #1;
    check("bp_xfer_valid", 64'(redirect_valid), 64'd1);
    check("bp_xfer_flush", 64'(flush), 64'd0);
    @(negedge clk);
    idle_inputs();
    check("bp_post_busy", 64'(busy), 64'd0);
    check("bp_post_valid", 64'(redirect_valid), 64'd0);

    // Asynchronous reset while writing mcause.
    @(negedge clk);
    drive_vec(vecs[1]);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("pre_rst_addr", 64'(csr_waddr), 64'h342);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 64'(csr_we), 64'd0);
    check("arst_addr", 64'(csr_waddr), 64'd0);
    check("arst_data", csr_wdata, 64'd0);
    check("arst_valid", 64'(redirect_valid), 64'd0);
    check("arst_pc", redirect_pc, 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_flush", 64'(flush), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
